multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning data/immediate width (>=14).
REQ-002 SHALL provide parameter REG_AW, default 4, meaning register-select width.
REQ-003 SHALL provide parameter SP_REG, default 13, meaning stack-pointer register index.
REQ-004 SHALL provide parameter STALL_LIMIT, default 255, meaning max memory-wait cycles before trap (1..65535).
REQ-005 SHALL use one clock; reset is asynchronous and active-low. Ports clk and rst_n are listed first.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port instr, input, 18, fetched instruction word, valid when mem_ack=1 in FETCH.
REQ-009 SHALL have port flags, input, 4, ALU flags: [1] Z, [2] L, [3] N.
REQ-010 SHALL have port mem_ack, input, 1, memory completion for the current mem_req.
REQ-011 SHALL have outputs mem_req (1), mem_we (1) and mem_addr_sel (2). mem_addr_sel encoding: 0 PC, 1 imm, 2 rf_src, 3 SP.
REQ-012 SHALL have outputs ir_we (1), pc_inc (1), pc_load (1) and pc_src (1). pc_src encoding: 0 imm, 1 stack data.
REQ-013 SHALL have outputs alu_op (4), alu_src_imm (1), flag_we (1), imm (DATA_W), rf_we (1), rf_dst (REG_AW), rf_src (REG_AW), sp_inc (1), sp_dec (1).
REQ-014 SHALL have outputs state (3) and trap (1). state is the current FSM state code; trap is a sticky illegal/timeout indicator.

Function
REQ-015 SHALL implement the FSM FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-016 In FETCH, SHALL assert mem_req=1 and mem_addr_sel=0.
- On mem_ack, SHALL pulse ir_we and pc_inc for that cycle, latch instr into the internal IR, and go to DECODE.
REQ-017 In DECODE (1 cycle), SHALL classify the IR by IR[17:16]:
- 00, IR[15:12]=0000: register ALU op, op=IR[7:4].
- 00, IR[15:12]=0001: register memory op; IR[7:4]=0 is load, 1 is store.
- 00, other IR[15:12]: immediate ALU op, op=IR[15:12], imm=zero-extended IR[7:0].
- 01/10: 14-bit address class; sub-op IR[17:14] selects CALL, RET, JL, JLE, JNE, JE, load-abs, store-abs; imm=zero-extended IR[13:0].
- 11: PUSH/POP/INCR/DECR.
- Any other encoding: go to TRAP.
REQ-018 In EXEC:
- ALU ops: SHALL drive alu_op and alu_src_imm, and pulse flag_we for compare/logic/shift ops.
- Branches: SHALL evaluate flags sampled in EXEC. JL takes on L|N; JLE on L|N|Z; JNE on !Z; JE on Z.
- Taken branch: SHALL pulse pc_load with pc_src=0, then go to FETCH.
- Not-taken branch: SHALL go to FETCH with no PC write.
REQ-019 Memory ops (load, store, PUSH, POP, CALL, RET) SHALL enter MEM.
- In MEM, SHALL hold mem_req=1 and the same mem_we/mem_addr_sel until mem_ack.
- Then SHALL go to WB for load/POP, and to FETCH for the others.
REQ-020 PUSH and CALL SHALL use address SP, write, and pulse sp_inc with mem_ack. CALL SHALL additionally pulse pc_load with pc_src=0.
REQ-021 POP and RET SHALL pulse sp_dec in EXEC, then read at SP in MEM. RET SHALL pulse pc_load with pc_src=1 on mem_ack.
REQ-022 In WB, SHALL pulse rf_we for exactly one cycle with rf_dst=IR[11:8] (POP: IR[13:10]).
REQ-023 POP targeting SP_REG or SP_REG-1 SHALL perform no register or SP write and SHALL complete as a NOP.
REQ-024 Every control pulse SHALL be high for exactly one cycle per instruction. All non-active outputs SHALL be 0.
REQ-025 SHALL count wait cycles while mem_req=1 and mem_ack=0.
- The counter SHALL clear on state entry.
- On reaching STALL_LIMIT, SHALL go to TRAP.
REQ-026 TRAP SHALL hold trap=1 with all strobes 0 until rst_n is asserted.
REQ-027 Latency with zero-wait memory:
- Register/immediate ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
- Branch: 3 cycles.
- Load/POP: 5 cycles.
- Store/PUSH/CALL/RET: 4 cycles.
REQ-028 mem_ack outside FETCH/MEM SHALL be ignored.

Reset
REQ-029 While rst_n=0, SHALL asynchronously force state=FETCH, IR=0, wait counter=0, trap=0, and all outputs 0 except mem_req.
REQ-030 mem_req SHALL rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-MEM SHALL abort the access without any rf_we, pc_load, or sp pulse.

Verification
REQ-032 Immediate ADD IR=0x0_2305, zero-wait -> state 0,1,2,4; alu_op=2, imm=0x0005, rf_dst=3, rf_we one pulse in cycle 4.
REQ-033 JE with flags=4'b0010 -> pc_load pulse in EXEC with pc_src=0. With flags=0 -> no pc_load; next state FETCH.
REQ-034 PUSH with mem_ack delayed 3 cycles -> mem_req/mem_we held 4 cycles, sp_inc pulses once on the ack cycle.
REQ-035 mem_ack held 0 for STALL_LIMIT=4 cycles in FETCH -> state=7 and trap=1 until rst_n=0.
REQ-036 POP into reg 13 -> no rf_we, no sp_dec; returns to FETCH.
REQ-037 rst_n pulsed low in MEM of a load -> state=0 immediately; no rf_we afterwards.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// a memory-wait watchdog and a sticky TRAP state for illegal or stalled operation.
module multicycle_control #(
   parameter int DATA_W      = 16,
   parameter int REG_AW      = 4,
   parameter int SP_REG      = 13,
   parameter int STALL_LIMIT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [17:0]       instr,
   input  logic [3:0]        flags,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_addr_sel,
   output logic              ir_we,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              pc_src,
   output logic [3:0]        alu_op,
   output logic              alu_src_imm,
   output logic              flag_we,
   output logic [DATA_W-1:0] imm,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_dst,
   output logic [REG_AW-1:0] rf_src,
   output logic              sp_inc,
   output logic              sp_dec,
   output logic [2:0]        state,
   output logic              trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [4:0] {
      K_ALU_R, K_ALU_I, K_LD_R, K_ST_R, K_CALL, K_RET, K_JL, K_JLE,
      K_JNE, K_JE, K_LD_A, K_ST_A, K_PUSH, K_POP, K_INCR, K_DECR, K_ILL
   } kind_t;

   localparam logic [15:0] LIMIT_M1  = 16'(STALL_LIMIT - 1);
   localparam logic [3:0]  SP_IDX    = 4'(SP_REG);
   localparam logic [3:0]  SP_IDX_M1 = 4'(SP_REG - 1);

   state_t             state_q;
   state_t             next_state;
   logic [17:0]        ir;
   logic [15:0]        wait_cnt;
   logic               run;
   kind_t              kind;
   logic               taken;
   logic               pop_nop;
   logic               is_load;
   logic               is_store;
   logic               stall_hit;
   logic               fld_en;
   logic [1:0]         sel_f;
   logic [3:0]         alu_f;
   logic [DATA_W-1:0]  imm_f;
   logic               unused_flag0;

   assign unused_flag0 = flags[0];

   always_comb begin
      kind = K_ILL;
      case (ir[17:16])
         2'b00: begin
            if (ir[15:12] == 4'h0) begin
               kind = K_ALU_R;
            end else if (ir[15:12] == 4'h1) begin
               if (ir[7:4] == 4'h0)      kind = K_LD_R;
               else if (ir[7:4] == 4'h1) kind = K_ST_R;
            end else begin
               kind = K_ALU_I;
            end
         end
         2'b01, 2'b10: begin
            case (ir[17:14])
               4'd4:    kind = K_CALL;
               4'd5:    kind = K_RET;
               4'd6:    kind = K_JL;
               4'd7:    kind = K_JLE;
               4'd8:    kind = K_JNE;
               4'd9:    kind = K_JE;
               4'd10:   kind = K_LD_A;
               4'd11:   kind = K_ST_A;
               default: kind = K_ILL;
            endcase
         end
         default: begin
            case (ir[15:14])
               2'b00:   kind = K_PUSH;
               2'b01:   kind = K_POP;
               2'b10:   kind = K_INCR;
               default: kind = K_DECR;
            endcase
         end
      endcase
   end

   // Flag bits: [1] Z, [2] L, [3] N
   always_comb begin
      case (kind)
         K_JL:    taken = flags[2] | flags[3];
         K_JLE:   taken = flags[2] | flags[3] | flags[1];
         K_JNE:   taken = ~flags[1];
         K_JE:    taken = flags[1];
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      imm_f = '0;
      alu_f = 4'h0;
      sel_f = 2'd3;
      case (kind)
         K_ALU_R: alu_f = ir[7:4];
         K_ALU_I: begin
            alu_f = ir[15:12];
            imm_f = DATA_W'(ir[7:0]);
         end
         K_LD_R, K_ST_R: sel_f = 2'd2;
         K_LD_A, K_ST_A: begin
            sel_f = 2'd1;
            imm_f = DATA_W'(ir[13:0]);
         end
         K_CALL, K_RET, K_JL, K_JLE, K_JNE, K_JE: imm_f = DATA_W'(ir[13:0]);
         default: ;
      endcase
   end

   // A POP that would overwrite the stack pointer pair is squashed to a NOP
   assign pop_nop   = (kind == K_POP) && ((ir[13:10] == SP_IDX) || (ir[13:10] == SP_IDX_M1));
   assign is_load   = (kind == K_LD_R) || (kind == K_LD_A) || (kind == K_POP);
   assign is_store  = (kind == K_ST_R) || (kind == K_ST_A) || (kind == K_PUSH) || (kind == K_CALL);
   assign stall_hit = (wait_cnt == LIMIT_M1);
   assign fld_en    = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM) || (state_q == S_WB);

   assign imm    = fld_en ? imm_f : '0;
   assign rf_dst = fld_en ? ((kind == K_POP) ? REG_AW'(ir[13:10]) : REG_AW'(ir[11:8])) : '0;
   assign rf_src = fld_en ? ((kind == K_PUSH) ? REG_AW'(ir[13:10]) : REG_AW'(ir[3:0])) : '0;
   assign state  = state_q;
   assign trap   = (state_q == S_TRAP);

   always_comb begin
      next_state   = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 2'd0;
      ir_we        = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      pc_src       = 1'b0;
      alu_op       = 4'h0;
      alu_src_imm  = 1'b0;
      flag_we      = 1'b0;
      rf_we        = 1'b0;
      sp_inc       = 1'b0;
      sp_dec       = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (run) begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_we      = 1'b1;
                  pc_inc     = 1'b1;
                  next_state = S_DECODE;
               end else if (stall_hit) begin
                  next_state = S_TRAP;
               end
            end
         end
         S_DECODE: next_state = (kind == K_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (kind)
               K_ALU_R, K_ALU_I: begin
                  alu_op      = alu_f;
                  alu_src_imm = (kind == K_ALU_I);
                  // Opcodes 8..15 are the compare/logic/shift group
                  flag_we     = alu_f[3];
                  next_state  = S_WB;
               end
               K_JL, K_JLE, K_JNE, K_JE: begin
                  pc_load    = taken;
                  next_state = S_FETCH;
               end
               K_INCR: begin
                  sp_inc     = 1'b1;
                  next_state = S_FETCH;
               end
               K_DECR: begin
                  sp_dec     = 1'b1;
                  next_state = S_FETCH;
               end
               K_POP: begin
                  if (pop_nop) begin
                     next_state = S_FETCH;
                  end else begin
                     sp_dec     = 1'b1;
                     next_state = S_MEM;
                  end
               end
               K_RET: begin
                  sp_dec     = 1'b1;
                  next_state = S_MEM;
               end
               default: next_state = S_MEM;
            endcase
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_we       = is_store;
            mem_addr_sel = sel_f;
            if (mem_ack) begin
               sp_inc     = (kind == K_PUSH) || (kind == K_CALL);
               pc_load    = (kind == K_CALL) || (kind == K_RET);
               pc_src     = (kind == K_RET);
               next_state = is_load ? S_WB : S_FETCH;
            end else if (stall_hit) begin
               next_state = S_TRAP;
            end
         end
         S_WB: begin
            rf_we      = 1'b1;
            next_state = S_FETCH;
         end
         S_TRAP:  next_state = S_TRAP;
         default: next_state = S_TRAP;
      endcase
   end

   // run delays mem_req until the first edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         ir       <= '0;
         wait_cnt <= '0;
         run      <= 1'b0;
      end else begin
         run     <= 1'b1;
         state_q <= next_state;
         if (ir_we) ir <= instr;
         if (next_state != state_q)      wait_cnt <= '0;
         else if (mem_req && !mem_ack)   wait_cnt <= wait_cnt + 16'd1;
      end
   end

endmodule
